ysyx_23060184_axi_lsu: RTL and testbench
========================================

Name: ysyx_23060184_axi_lsu

Overview:
Parametrised single-outstanding AXI4 load/store master that replaces the fixed 32-bit SoC memory unit. It takes one LSU request (RISC-V funct3 encoding) and issues one single-beat read or write with byte-lane steering and strobes. It adds explicit request/response handshakes, parallel AW/W issue, misalignment detection, bus-error reporting and a timeout watchdog.

Parameters:
DATA_WIDTH, 32, AXI data and LSU data width; 32 or 64.
ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 1024, bus-phase cycles before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  LSU request valid
req_ready  out  1  unit idle, can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_funct3  in  3  [1:0] size (0 byte, 1 half, 2 word, 3 dword); [2] unsigned load
req_wdata  in  DATA_WIDTH  store data, LSB-aligned
resp_valid  out  1  response valid
resp_ready  in  1  LSU accepts response
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, unsupported size, non-OKAY resp, or timeout
araddr  out  ADDR_WIDTH  latched req_addr
arsize  out  3  {0, size}
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_WIDTH  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_WIDTH  latched req_addr
awsize  out  3  {0, size}
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  DATA_WIDTH  lane-shifted store data
wstrb  out  DATA_WIDTH/8  byte strobes
wlast  out  1  equals wvalid (single beat)
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset values: state IDLE, req_ready=1, every valid and ready output 0, resp_rdata=0, resp_err=0, watchdog counter 0. Reset has priority in every state; a transfer in flight is abandoned.
- FSM states: IDLE, AR, R, AWW, B, RESP. In IDLE, req_valid&&req_ready latches addr, funct3 and wdata, and drops req_ready. The request is rejected with resp_err=1 and no bus activity, going straight to RESP, when the address is misaligned (addr mod 2^size != 0) or when size=3 with DATA_WIDTH=32.
- Read path: in AR, arvalid=1 is held until arready. Then arvalid=0, rready=1 and the FSM moves to R. In R, on rvalid the unit captures the lane at addr offset (offset = addr mod DATA_WIDTH/8), zero-extends if funct3[2] else sign-extends, sets err = (rresp != 0), drops rready and moves to RESP.
- Write path: in AWW, awvalid and wvalid rise together and each drops on its own handshake. The FSM moves to B with bready=1 only once both have completed; either order or simultaneous completion is allowed.
- Write data and strobes: wdata = req_wdata << 8*offset, and wstrb = ((1 << 2^size) - 1) << offset. In B, on bvalid the unit sets err = (bresp != 0), drops bready and moves to RESP.
- RESP: resp_valid is held with stable data until resp_ready. The FSM then returns to IDLE and req_ready=1 on the next edge.
- Minimum latency with zero-wait slave, request accept to resp_valid: read 3 cycles, write 3 cycles, rejected request 1 cycle.
- Watchdog: the counter clears on request accept and increments every cycle in AR/R/AWW/B. When it reaches TIMEOUT_CYCLES, all AXI valid and ready outputs drop, resp_err=1, resp_rdata=0, and the FSM moves to RESP.

Test Plan:
- DATA_WIDTH=32, lb addr 0x0F000003, rdata 0x80FF0000, rresp 0 -> arsize 0, resp_rdata 0xFFFFFF80, err 0. lbu at the same address -> 0x00000080.
- sh addr 0x0F000002, wdata 0x1234ABCD; wready immediate, awready after 3 cycles -> wdata 0xABCD0000, wstrb 0b1100, wvalid drops first, bready rises only after the AW handshake.
- lw addr 0x0F000002 -> arvalid never asserted, resp_valid 1 cycle after accept with err 1. DATA_WIDTH=64 ld addr 0x8 -> full 64-bit rdata returned.
- TIMEOUT_CYCLES=16, arready held 0 -> resp_err 1 after 16 cycles, arvalid 0. Separately, rresp 2'b10 -> err 1. Reset asserted in B -> bready 0 and req_ready 1 after the edge.

Source files
------------

// File: rtl/ysyx_23060184_axi_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060184_axi_lsu
// Description : Single-outstanding AXI4 load/store master. Accepts one LSU
//               request (RISC-V funct3 size/sign encoding), issues one
//               single-beat read or write with byte-lane steering, and
//               returns extended load data or an error flag. Misaligned or
//               unsupported requests are rejected without bus traffic, and a
//               watchdog aborts bus phases that never complete.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060184_axi_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    // LSU request / response
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2:0]              req_funct3,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    // AXI read address / data
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arsize,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    // AXI write address / data / response
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awsize,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_WD_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);
    localparam logic c_WD_ON    = (TIMEOUT_CYCLES != 0);
    localparam logic c_NO_DWORD = (DATA_WIDTH == 32);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AWW  = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [c_STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic [c_WD_W-1:0]       wd_q, wd_d;

    logic [c_OFF_W-1:0]      w_req_off;
    logic                    w_misaligned;
    logic                    w_reject;
    logic [c_STRB_W-1:0]     w_lane_base;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_mask;
    logic                    w_sign;
    logic [DATA_WIDTH-1:0]   w_load_ext;
    logic [c_WD_W-1:0]       w_wd_inc;
    logic                    w_timeout;
    logic                    w_in_bus;
    logic                    w_aw_done;
    logic                    w_w_done;

    // Request-side decode: lane offset and the strobe pattern before shifting.
    assign w_req_off   = req_addr[c_OFF_W-1:0];
    assign w_lane_base = c_STRB_W'((32'd1 << (32'd1 << req_funct3[1:0])) - 32'd1);
    assign w_reject    = w_misaligned | (c_NO_DWORD & (req_funct3[1:0] == 2'd3));

    // Natural alignment check: low address bits must be zero for the access size.
    always_comb begin
        case (req_funct3[1:0])
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    // Load path: move the addressed lane to bit 0, then zero- or sign-extend it.
    assign w_shifted = rdata >> {addr_q[c_OFF_W-1:0], 3'b000};

    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        case (funct3_q[1:0])
            2'd0: begin
                w_mask = DATA_WIDTH'(8'hFF);
                w_sign = w_shifted[7];
            end
            2'd1: begin
                w_mask = DATA_WIDTH'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            2'd2: begin
                w_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
        w_load_ext = (w_shifted & w_mask) | ((w_sign & ~funct3_q[2]) ? ~w_mask : '0);
    end

    // Watchdog: abort when the bus-phase count is about to reach the limit.
    assign w_wd_inc  = wd_q + c_WD_W'(1);
    assign w_timeout = c_WD_ON & (w_wd_inc == c_WD_LIMIT);
    assign w_in_bus  = (state_q == S_AR) || (state_q == S_R) ||
                       (state_q == S_AWW) || (state_q == S_B);

    // AW and W complete independently; a channel is done once its valid is low
    // or it handshakes this cycle.
    assign w_aw_done = ~awvalid_q | awready;
    assign w_w_done  = ~wvalid_q | wready;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wd_d         = wd_q;

        if (w_in_bus && c_WD_ON) begin
            wd_d = w_wd_inc;
        end

        if (w_in_bus && w_timeout) begin
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = S_RESP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_d  = 1'b0;
                        addr_d       = req_addr;
                        funct3_d     = req_funct3;
                        wdata_d      = req_wdata << {w_req_off, 3'b000};
                        wstrb_d      = w_lane_base << w_req_off;
                        wd_d         = '0;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                        if (w_reject) begin
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                            state_d      = S_RESP;
                        end else if (req_write) begin
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            state_d   = S_AWW;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        state_d   = S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready_d     = 1'b0;
                        resp_err_d   = (rresp != 2'b00);
                        resp_rdata_d = (rresp != 2'b00) ? '0 : w_load_ext;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end
                end
                S_AWW: begin
                    if (awready) begin
                        awvalid_d = 1'b0;
                    end
                    if (wready) begin
                        wvalid_d = 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        bready_d = 1'b1;
                        state_d  = S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready_d     = 1'b0;
                        resp_err_d   = (bresp != 2'b00);
                        resp_rdata_d = '0;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_d = 1'b0;
                        req_ready_d  = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wd_q         <= wd_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign araddr     = addr_q;
    assign arsize     = {1'b0, funct3_q[1:0]};
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, funct3_q[1:0]};
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wlast      = wvalid_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_axi_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060184_axi_lsu
// Description : Self-checking bench: a 32-bit instance with a short watchdog
//               driven by a delay-programmable AXI slave and a transaction
//               model, plus a 64-bit instance behind a zero-wait slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_axi_lsu;

    localparam int c_TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    // 64-bit instance signals
    logic        req_valid6, req_ready6, req_write6;
    logic [31:0] req_addr6;
    logic [63:0] req_wdata6, resp_rdata6, rdata6, wdata6;
    logic [2:0]  req_funct3_6, arsize6, awsize6;
    logic        resp_valid6, resp_ready6, resp_err6;
    logic [31:0] araddr6, awaddr6;
    logic        arvalid6, rready6, awvalid6, wvalid6, wlast6, bready6;
    logic [7:0]  wstrb6;
    wire         rvalid6 = rready6;
    wire         bvalid6 = bready6;

    ysyx_23060184_axi_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    ysyx_23060184_axi_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(1024)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_write(req_write6),
        .req_addr(req_addr6), .req_funct3(req_funct3_6), .req_wdata(req_wdata6),
        .resp_valid(resp_valid6), .resp_ready(resp_ready6), .resp_rdata(resp_rdata6), .resp_err(resp_err6),
        .araddr(araddr6), .arsize(arsize6), .arvalid(arvalid6), .arready(1'b1),
        .rdata(rdata6), .rresp(2'b00), .rvalid(rvalid6), .rready(rready6),
        .awaddr(awaddr6), .awsize(awsize6), .awvalid(awvalid6), .awready(1'b1),
        .wdata(wdata6), .wstrb(wstrb6), .wlast(wlast6), .wvalid(wvalid6), .wready(1'b1),
        .bresp(2'b00), .bvalid(bvalid6), .bready(bready6)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: outcome of one request from the access rules.
    function automatic void model(input bit wr, input logic [63:0] addr, input logic [2:0] f3,
                                  input logic [63:0] wd, input logic [63:0] rd, input logic [1:0] rsp,
                                  input int nbus, input int to, input int dw,
                                  output bit bus, output logic [63:0] o_wdata, output logic [7:0] o_wstrb,
                                  output logic [63:0] o_rdata, output bit o_err, output int o_lat);
        int nbytes, lanes, off;
        logic [127:0] field, full, dmask;
        nbytes  = 1 << f3[1:0];
        lanes   = dw / 8;
        off     = int'(addr % 64'(lanes));
        dmask   = (128'd1 << dw) - 128'd1;
        full    = 128'd1 << (8 * nbytes);
        bus     = ((addr % 64'(nbytes)) == 0) && (nbytes <= lanes);
        o_wdata = 64'((128'(wd) << (8 * off)) & dmask);
        o_wstrb = 8'(((1 << nbytes) - 1) << off);
        o_rdata = '0;
        o_err   = 1'b1;
        o_lat   = 1;
        if (bus) begin
            if (to != 0 && nbus >= to) begin
                o_lat = to + 1;
            end else begin
                o_lat = nbus + 1;
                o_err = (rsp != 2'b00);
                if (!wr && !o_err) begin
                    field = (128'(rd) >> (8 * off)) % full;
                    if (!f3[2] && field >= full / 2) field = field + (dmask + 128'd1) - full;
                    o_rdata = 64'(field & dmask);
                end
            end
        end
    endfunction

    // Current expectations shared with the compare process
    bit          active = 1'b0;
    bit          exp_bus, exp_write, exp_err;
    logic [31:0] exp_addr;
    logic [2:0]  exp_f3;
    logic [63:0] exp_wdata, exp_rdata;
    logic [7:0]  exp_wstrb;
    int          exp_lat;

    // Per-transaction observations
    int          lat, w_drop, aw_fire_cyc, b_rise;
    bit          saw_ar, saw_aw, saw_w, ready_after;
    logic [31:0] g_rdata, g_wdata;
    logic [3:0]  g_wstrb;
    logic [2:0]  g_arsize;
    logic        g_err;
    logic [4:0]  g_bus_at_resp;

    // Compare process: every cycle of a transaction, outputs against the model
    always @(negedge clk) begin
        if (!rst && active) begin
            chk("wlast_eq_wvalid", wlast, wvalid);
            chk("ar_allowed", arvalid & ~(exp_bus & ~exp_write), 1'b0);
            chk("aw_allowed", (awvalid | wvalid) & ~(exp_bus & exp_write), 1'b0);
            if (arvalid) begin
                chk("araddr", araddr, exp_addr);
                chk("arsize", arsize, {1'b0, exp_f3[1:0]});
            end
            if (awvalid) begin
                chk("awaddr", awaddr, exp_addr);
                chk("awsize", awsize, {1'b0, exp_f3[1:0]});
            end
            if (wvalid) begin
                chk("wdata", wdata, exp_wdata);
                chk("wstrb", wstrb, exp_wstrb);
            end
            if (resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", resp_err, exp_err);
            end
            if (req_ready) chk("idle_quiet", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 6'd0);
        end
    end

    // One request on the 32-bit instance against a slave with per-channel delays
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rsp,
                          input int ar_d, input int r_d, input int aw_d, input int w_d,
                          input int b_d, input int resp_d, input bit rst_in_b);
        int nbus, ar_w, r_w, aw_w, w_w, b_w, rs_w;
        bit done, p_ar, p_r, p_aw, p_w, p_b, p_rs;
        logic [63:0] e_wd, e_rd;
        logic [7:0]  e_ws;
        nbus = wr ? (((aw_d > w_d) ? aw_d : w_d) + b_d + 2) : (ar_d + r_d + 2);
        model(wr, 64'(addr), f3, 64'(wd), 64'(rd), rsp, nbus, c_TO, 32,
              exp_bus, e_wd, e_ws, e_rd, exp_err, exp_lat);
        exp_wdata = e_wd; exp_wstrb = e_ws; exp_rdata = e_rd;
        exp_write = wr; exp_addr = addr; exp_f3 = f3;
        lat = 0; w_drop = 0; aw_fire_cyc = 0; b_rise = 0;
        saw_ar = 0; saw_aw = 0; saw_w = 0; ready_after = 0; done = 0;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0; rs_w = 0;
        p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0; p_rs = 0;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        chk("req_ready_before", req_ready, 1'b1);
        req_valid = 1; req_write = wr; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        rresp = rsp; bresp = rsp; rdata = rd;
        active = 1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 0;
            if (p_ar && arready) arready = 0;
            if (p_r && rvalid)   rvalid = 0;
            if (p_aw && awready) begin awready = 0; aw_fire_cyc = cyc; end
            if (p_w && wready)   wready = 0;
            if (p_b && bvalid)   bvalid = 0;
            if (p_rs && resp_ready) begin
                resp_ready = 0; done = 1; ready_after = req_ready;
            end else begin
                if (arvalid) begin saw_ar = 1; g_arsize = arsize; end
                if (awvalid) saw_aw = 1;
                if (wvalid && !saw_w) begin saw_w = 1; g_wdata = wdata; g_wstrb = wstrb; end
                if (!wvalid && saw_w && w_drop == 0) w_drop = cyc;
                if (bready && b_rise == 0) b_rise = cyc;
                if (resp_valid && lat == 0) begin
                    lat = cyc; g_rdata = resp_rdata; g_err = resp_err;
                    g_bus_at_resp = {arvalid, rready, awvalid, wvalid, bready};
                end
                if (rst_in_b && bready) begin
                    rst = 1;
                    @(negedge clk);
                    chk("rstB_bready", bready, 1'b0);
                    chk("rstB_req_ready", req_ready, 1'b1);
                    chk("rstB_quiet", {awvalid, wvalid, resp_valid, resp_err}, 4'd0);
                    rst = 0;
                    bvalid = 0;
                    done = 1;
                end else begin
                    if (arvalid) begin if (ar_w >= ar_d) arready = 1; ar_w++; end
                    if (rready)  begin if (r_w >= r_d) rvalid = 1; r_w++; end
                    if (awvalid) begin if (aw_w >= aw_d) awready = 1; aw_w++; end
                    if (wvalid)  begin if (w_w >= w_d) wready = 1; w_w++; end
                    if (bready)  begin if (b_w >= b_d) bvalid = 1; b_w++; end
                    if (resp_valid) begin if (rs_w >= resp_d) resp_ready = 1; rs_w++; end
                    p_ar = arvalid; p_r = rready; p_aw = awvalid; p_w = wvalid;
                    p_b = bready; p_rs = resp_valid;
                end
            end
        end
        active = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; resp_ready = 0;
        chk("txn_done", done, 1'b1);
        if (!rst_in_b) begin
            chk("latency", lat, exp_lat);
            chk("bus_activity", saw_ar | saw_aw, exp_bus);
            chk("resp_bus_idle", g_bus_at_resp, 5'd0);
            chk("ready_after_resp", ready_after, 1'b1);
        end
    endtask

    // One request on the 64-bit instance (zero-wait slave)
    task automatic do64(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [63:0] wd, input logic [63:0] rd,
                        output int l6, output logic [63:0] o_rd, output logic o_err,
                        output logic [63:0] o_wd, output logic [7:0] o_ws);
        l6 = 0; o_rd = '0; o_err = 0; o_wd = '0; o_ws = '0;
        rdata6 = rd;
        req_valid6 = 1; req_write6 = wr; req_addr6 = addr; req_funct3_6 = f3; req_wdata6 = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 20 && l6 == 0; cyc++) begin
            @(negedge clk);
            req_valid6 = 0;
            if (wvalid6) begin o_wd = wdata6; o_ws = wstrb6; end
            if (resp_valid6) begin l6 = cyc; o_rd = resp_rdata6; o_err = resp_err6; end
        end
        resp_ready6 = 1;
        @(negedge clk);
        resp_ready6 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    int          l6;
    logic [63:0] rd6, wd6;
    logic [7:0]  ws6;
    logic        e6;

    initial begin
        rst = 1;
        req_valid = 0; req_write = 0; req_addr = 0; req_funct3 = 0; req_wdata = 0; resp_ready = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
        req_valid6 = 0; req_write6 = 0; req_addr6 = 0; req_funct3_6 = 0; req_wdata6 = 0;
        resp_ready6 = 0; rdata6 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 8'b1000_0000);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_ctrl64", {req_ready6, arvalid6, awvalid6, wvalid6, resp_valid6}, 5'b10000);
        rst = 0;
        @(negedge clk);

        // lb / lbu at byte offset 3
        do_req(0, 32'h0F00_0003, 3'b000, 0, 32'h80FF_0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("lb_data", g_rdata, 32'hFFFF_FF80);
        chk("lb_err", g_err, 1'b0);
        chk("lb_arsize", g_arsize, 3'd0);
        chk("lb_lat", lat, 3);
        do_req(0, 32'h0F00_0003, 3'b100, 0, 32'h80FF_0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("lbu_data", g_rdata, 32'h0000_0080);

        // sh with immediate W, AW accepted three cycles late
        do_req(1, 32'h0F00_0002, 3'b001, 32'h1234_ABCD, 0, 2'b00, 0, 0, 3, 0, 0, 0, 0);
        chk("sh_wdata", g_wdata, 32'hABCD_0000);
        chk("sh_wstrb", g_wstrb, 4'b1100);
        chk("sh_w_first", (w_drop != 0) && (w_drop < aw_fire_cyc), 1'b1);
        chk("sh_bready_after_aw", (b_rise != 0) && (b_rise >= aw_fire_cyc), 1'b1);
        chk("sh_resp", {g_rdata, 31'd0, g_err}, 64'd0);

        // Misaligned lw and dword on a 32-bit bus: rejected, no bus activity
        do_req(0, 32'h0F00_0002, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("mis_lat", lat, 1);
        chk("mis_err", g_err, 1'b1);
        chk("mis_no_ar", saw_ar, 1'b0);
        do_req(0, 32'h0F00_0008, 3'b011, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("ld32_err", g_err, 1'b1);

        // Halfword loads with slave waits
        do_req(0, 32'h0F00_0002, 3'b001, 0, 32'h8001_1234, 2'b00, 1, 2, 0, 0, 0, 1, 0);
        chk("lh_data", g_rdata, 32'hFFFF_8001);
        do_req(0, 32'h0F00_0000, 3'b101, 0, 32'h8001_1234, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("lhu_data", g_rdata, 32'h0000_1234);

        // Bus errors
        do_req(0, 32'h0F00_0004, 3'b010, 0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        chk("rresp_err", {g_rdata, 31'd0, g_err}, 64'd1);
        do_req(1, 32'h0F00_0000, 3'b010, 32'h5555_AAAA, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("bresp_err", g_err, 1'b1);

        // sb with late W, late B, held response
        do_req(1, 32'h0F00_0001, 3'b000, 32'h0000_00A5, 0, 2'b00, 0, 0, 0, 2, 1, 2, 0);
        chk("sb_wdata", g_wdata, 32'h0000_A500);
        chk("sb_wstrb", g_wstrb, 4'b0010);
        chk("sb_lat", lat, 6);

        // Watchdog on AR and on B
        do_req(0, 32'h0F00_0010, 3'b010, 0, 0, 2'b00, 1000, 0, 0, 0, 0, 0, 0);
        chk("to_ar_lat", lat, 17);
        chk("to_ar_err", g_err, 1'b1);
        do_req(1, 32'h0F00_0010, 3'b010, 32'h1, 0, 2'b00, 0, 0, 0, 0, 1000, 0, 0);
        chk("to_b_err", g_err, 1'b1);

        // Reset while waiting for B, then recovery
        do_req(1, 32'h0F00_0020, 3'b010, 32'hCAFE_F00D, 0, 2'b00, 0, 0, 0, 0, 1000, 0, 1);
        do_req(0, 32'h0F00_0001, 3'b100, 0, 32'h0000_7F00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("recover_data", g_rdata, 32'h0000_007F);

        // 64-bit instance
        do64(0, 32'h8, 3'b011, 0, 64'h8123_4567_89AB_CDEF, l6, rd6, e6, wd6, ws6);
        chk("ld64_data", rd6, 64'h8123_4567_89AB_CDEF);
        chk("ld64_err", e6, 1'b0);
        chk("ld64_lat", l6, 3);
        do64(0, 32'hC, 3'b010, 0, 64'h8123_4567_89AB_CDEF, l6, rd6, e6, wd6, ws6);
        chk("lw64_data", rd6, 64'hFFFF_FFFF_8123_4567);
        do64(1, 32'h6, 3'b001, 64'hBEEF, 0, l6, rd6, e6, wd6, ws6);
        chk("sh64_wdata", wd6, 64'hBEEF_0000_0000_0000);
        chk("sh64_wstrb", ws6, 8'hC0);
        chk("sh64_err", e6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
